// File: rtl/if_fetch_unit_if.sv
// Memory-side fetch handshake between if_fetch_unit (master) and the memory controller (slave).
interface if_fetch_unit_if #(
   parameter int unsigned PC_WIDTH = 32
) ();

   logic                mem_req_out;
   logic [PC_WIDTH-1:0] mem_addr_out;
   logic                mem_done_in;
   logic [PC_WIDTH-1:0] mem_data_in;

   modport master (
      output mem_req_out,
      output mem_addr_out,
      input  mem_done_in,
      input  mem_data_in
   );

   modport slave (
      input  mem_req_out,
      input  mem_addr_out,
      output mem_done_in,
      output mem_data_in
   );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches, buffers one instruction for IF/ID.
// Optional IF_STALL_CNT_EN adds saturating stall-cycle and redirect counters.
module if_fetch_unit #(
   parameter int unsigned         PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [5:0]          stall_in,
   input  logic                branch_en_in,
   input  logic [PC_WIDTH-1:0] branch_target_in,
   if_fetch_unit_if.master     mem_if,
   output logic                if_stall_out,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [PC_WIDTH-1:0] inst_out,
   output logic                inst_valid_out
`ifdef IF_STALL_CNT_EN
   ,
   output logic [31:0]         stall_cnt_out,
   output logic [31:0]         redirect_cnt_out
`endif
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } state_e;

   state_e              state_q,    state_d;
   logic [PC_WIDTH-1:0] pc_q,       pc_d;
   logic                kill_q,     kill_d;
   logic [PC_WIDTH-1:0] kill_tgt_q, kill_tgt_d;
   logic [PC_WIDTH-1:0] addr_q,     addr_d;
   logic [PC_WIDTH-1:0] inst_q,     inst_d;
   logic [PC_WIDTH-1:0] pc_buf_q,   pc_buf_d;
   logic                valid_q,    valid_d;

   // Stall bits above the IF/ID hold are meant for later pipeline stages.
   logic unused_stall_hi;
   assign unused_stall_hi = ^stall_in[5:2];

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         kill_tgt_q <= '0;
         addr_q     <= '0;
         inst_q     <= '0;
         pc_buf_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         kill_tgt_q <= kill_tgt_d;
         addr_q     <= addr_d;
         inst_q     <= inst_d;
         pc_buf_q   <= pc_buf_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state logic; a redirect always wins over consumption or delivery.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      kill_tgt_d = kill_tgt_q;
      addr_d     = addr_q;
      inst_d     = inst_q;
      pc_buf_d   = pc_buf_q;
      valid_d    = valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (branch_en_in) begin
               pc_d    = branch_target_in;
               valid_d = 1'b0;
            end else if (!stall_in[0]) begin
               addr_d  = pc_q;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (mem_if.mem_done_in) begin
               if (branch_en_in) begin
                  pc_d    = branch_target_in;
                  kill_d  = 1'b0;
                  state_d = S_IDLE;
               end else if (kill_q) begin
                  pc_d    = kill_tgt_q;
                  kill_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  inst_d   = mem_if.mem_data_in;
                  pc_buf_d = pc_q;
                  valid_d  = 1'b1;
                  state_d  = S_FULL;
               end
            end else if (branch_en_in) begin
               // Request stays in flight; its data is dropped on arrival.
               kill_d     = 1'b1;
               kill_tgt_d = branch_target_in;
            end
         end

         S_FULL: begin
            if (branch_en_in) begin
               pc_d    = branch_target_in;
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else if (!stall_in[1]) begin
               pc_d    = pc_q + PC_WIDTH'(4);
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_if.mem_req_out  = (state_q == S_WAIT);
   assign mem_if.mem_addr_out = addr_q;
   assign if_stall_out        = (state_q == S_WAIT);
   assign pc_out              = pc_buf_q;
   assign inst_out            = inst_q;
   assign inst_valid_out      = valid_q;

`ifdef IF_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] redirect_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if ((state_q == S_WAIT) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (branch_en_in && (redirect_cnt_q != '1)) begin
            redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt_out    = stall_cnt_q;
   assign redirect_cnt_out = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table of fetch transactions plus redirect/reset corner sequences.
module tb_if_fetch_unit;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    stall;
   logic          br_en;
   logic [W-1:0]  br_tgt;
   logic          if_stall;
   logic [W-1:0]  pc_o;
   logic [W-1:0]  inst_o;
   logic          valid_o;
`ifdef IF_STALL_CNT_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   redir_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_unit_if #(.PC_WIDTH(W)) mem_if ();

   if_fetch_unit #(
      .PC_WIDTH (W),
      .RESET_PC ('0)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst_n),
      .stall_in         (stall),
      .branch_en_in     (br_en),
      .branch_target_in (br_tgt),
      .mem_if           (mem_if),
      .if_stall_out     (if_stall),
      .pc_out           (pc_o),
      .inst_out         (inst_o),
      .inst_valid_out   (valid_o)
`ifdef IF_STALL_CNT_EN
      ,
      .stall_cnt_out    (stall_cnt),
      .redirect_cnt_out (redir_cnt)
`endif
   );

   typedef struct {
      logic [W-1:0] addr;
      int           lat;
      logic [W-1:0] data;
      int           hold;
   } vec_t;

   typedef struct {
      logic [W-1:0] pc;
      logic [W-1:0] inst;
   } sb_t;

   sb_t sb_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Wait (bounded) for a request, then check its address.
   task automatic wait_req(input logic [W-1:0] exp_addr);
      int n = 0;
      while (mem_if.mem_req_out !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("req_seen", mem_if.mem_req_out, 1'b1);
      chk("req_addr", mem_if.mem_addr_out, exp_addr);
      chk1("req_if_stall", if_stall, 1'b1);
   endtask

   // Answer the outstanding request after v.lat wait cycles, check delivery, optionally hold in FULL.
   task automatic complete(input vec_t v);
      sb_t e;
      sb_t got;
      for (int i = 1; i < v.lat; i++) begin
         @(negedge clk);
         chk1("wait_if_stall", if_stall, 1'b1);
         chk("wait_addr_stable", mem_if.mem_addr_out, v.addr);
      end
      mem_if.mem_done_in = 1'b1;
      mem_if.mem_data_in = v.data;
      e.pc   = v.addr;
      e.inst = v.data;
      sb_q.push_back(e);
      @(negedge clk);
      mem_if.mem_done_in = 1'b0;
      mem_if.mem_data_in = W'($urandom);
      got = sb_q.pop_front();
      chk1("inst_valid", valid_o, 1'b1);
      chk("inst_out", inst_o, got.inst);
      chk("pc_out", pc_o, got.pc);
      chk1("full_no_req", mem_if.mem_req_out, 1'b0);
      chk1("full_no_stall", if_stall, 1'b0);
      if (v.hold > 0) begin
         stall = 6'b000111;
         repeat (v.hold) begin
            @(negedge clk);
            chk1("hold_valid", valid_o, 1'b1);
            chk("hold_inst", inst_o, got.inst);
            chk("hold_pc", pc_o, got.pc);
            chk1("hold_no_req", mem_if.mem_req_out, 1'b0);
         end
         stall = 6'b000000;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      vec_t v;
      tbl[0] = '{32'h0000_0000, 3, 32'h0000_0013, 0};
      tbl[1] = '{32'h0000_0004, 1, 32'h0010_0093, 4};
      tbl[2] = '{32'h0000_0008, 5, 32'h0020_0113, 0};
      tbl[3] = '{32'h0000_000C, 2, 32'h0030_0193, 2};

      rst_n  = 1'b0;
      stall  = 6'b000000;
      br_en  = 1'b0;
      br_tgt = '0;
      mem_if.mem_done_in = 1'b0;
      mem_if.mem_data_in = '0;

      // Reset values.
      @(negedge clk);
      chk1("rst_req", mem_if.mem_req_out, 1'b0);
      chk("rst_addr", mem_if.mem_addr_out, 32'h0);
      chk1("rst_if_stall", if_stall, 1'b0);
      chk("rst_pc_out", pc_o, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      chk1("rst_valid", valid_o, 1'b0);

      // No request while stall_in[0] is held.
      stall = 6'b000001;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk1("stall0_no_req", mem_if.mem_req_out, 1'b0);
      end
      stall = 6'b000000;

      foreach (tbl[i]) begin
         wait_req(tbl[i].addr);
         complete(tbl[i]);
      end

      // Redirect in FULL beats consumption; then PC wraps past the top.
      br_en  = 1'b1;
      br_tgt = 32'hFFFF_FFFC;
      @(negedge clk);
      br_en = 1'b0;
      chk1("redir_full_valid", valid_o, 1'b0);
      chk1("redir_full_req", mem_if.mem_req_out, 1'b0);
      v = '{32'hFFFF_FFFC, 2, 32'h0000_006F, 0};
      wait_req(v.addr);
      complete(v);
      v = '{32'h0000_0000, 1, 32'h0000_0073, 0};
      wait_req(v.addr);
      complete(v);

      // Two redirects during WAIT: newest target kept, fetched data dropped.
      wait_req(32'h4);
      br_en  = 1'b1;
      br_tgt = 32'h180;
      @(negedge clk);
      br_tgt = 32'h100;
      @(negedge clk);
      br_en = 1'b0;
      chk1("kill_if_stall", if_stall, 1'b1);
      chk1("kill_req_held", mem_if.mem_req_out, 1'b1);
      chk("kill_addr_stable", mem_if.mem_addr_out, 32'h4);
      @(negedge clk);
      mem_if.mem_done_in = 1'b1;
      mem_if.mem_data_in = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_if.mem_done_in = 1'b0;
      chk1("kill_valid", valid_o, 1'b0);
      chk1("kill_req_drop", mem_if.mem_req_out, 1'b0);
      v = '{32'h0000_0100, 1, 32'h0000_0013, 0};
      wait_req(v.addr);
      complete(v);

      // Redirect coinciding with completion.
      wait_req(32'h104);
      br_en  = 1'b1;
      br_tgt = 32'h200;
      mem_if.mem_done_in = 1'b1;
      mem_if.mem_data_in = 32'h0000_0BAD;
      @(negedge clk);
      br_en = 1'b0;
      mem_if.mem_done_in = 1'b0;
      chk1("same_cyc_valid", valid_o, 1'b0);
      chk1("same_cyc_req", mem_if.mem_req_out, 1'b0);
      v = '{32'h0000_0200, 2, 32'h0040_0213, 0};
      wait_req(v.addr);
      complete(v);

      // Reset mid-fetch, then a late completion in IDLE is ignored.
      wait_req(32'h204);
      rst_n = 1'b0;
      #1;
      chk1("midrst_req", mem_if.mem_req_out, 1'b0);
      chk1("midrst_if_stall", if_stall, 1'b0);
      chk("midrst_addr", mem_if.mem_addr_out, 32'h0);
      @(negedge clk);
      stall = 6'b000001;
      rst_n = 1'b1;
      mem_if.mem_done_in = 1'b1;
      mem_if.mem_data_in = 32'h0000_1234;
      @(negedge clk);
      mem_if.mem_done_in = 1'b0;
      chk1("late_done_valid", valid_o, 1'b0);
      chk1("late_done_req", mem_if.mem_req_out, 1'b0);
      stall = 6'b000000;
      v = '{32'h0000_0000, 1, 32'h0000_0013, 0};
      wait_req(v.addr);
      complete(v);

`ifdef IF_STALL_CNT_EN
      // Counters: two 3-cycle fetches and one redirect after a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      chk("cnt_rst_stall", stall_cnt, 32'd0);
      chk("cnt_rst_redir", redir_cnt, 32'd0);
      rst_n = 1'b1;
      v = '{32'h0000_0000, 3, 32'h0000_0013, 0};
      wait_req(v.addr);
      complete(v);
      v = '{32'h0000_0004, 3, 32'h0000_0093, 0};
      wait_req(v.addr);
      complete(v);
      br_en  = 1'b1;
      br_tgt = 32'h40;
      @(negedge clk);
      br_en = 1'b0;
      stall = 6'b000001;
      @(negedge clk);
      chk("cnt_stall", stall_cnt, 32'd6);
      chk("cnt_redir", redir_cnt, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
